remap_cache_filler: RTL
=======================

# remap_cache_filler

Write-side controller for the banked remap cache: accepts vector fill data tagged with an input-config id, allocates the next slot in that id's circular region of the cache, and drives the cache's `wad` write port with `wid`, `whiaddr` and the data. It consumes the cache's `free` retire events to reclaim slots, and back-pressures the fill stream when an id's region is full. It sits between the DRAM read-response path and the remap cache inside the read pipeline.

## Interface
- `LBW`, default `TauCfg::LOCAL_ADDR_BW0`: local address width. `DBW = TauCfg::DATA_BW`, `N_ICFG = TauCfg::N_ICFG`, `VSIZE = TauCfg::VSIZE`.
- Derived: `ICFG_BW = $clog2(N_ICFG+1)`, `CV_BW = $clog2(VSIZE)`, `HBW = LBW-CV_BW` (row address width), `CNT_BW = HBW+1`.
- `i_clk` in 1: clock; the only clock.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_cfg_dval` in 1: load region configuration for all ids.
- `i_cfg_base` in `HBW` x `[N_ICFG]`: first row of each id's region.
- `i_cfg_size` in `CNT_BW` x `[N_ICFG]`: rows per region, 0..`1<<HBW`; 0 disables the id.
- `i_din_rdy` in 1, `o_din_ack` out 1: fill stream rdyack.
- `i_din_id` in `ICFG_BW`: target id of the fill.
- `i_din_data` in `DBW` x `[VSIZE]`: one row of vector data.
- `i_free_dval` in 1, `i_free_id` in `ICFG_BW`: one row retired by the cache reader.
- `o_wad_dval` out 1, `o_wid` out `ICFG_BW`, `o_whiaddr` out `HBW`, `o_wdata` out `DBW` x `[VSIZE]`: cache write port.
- `o_idle` out 1: every region empty and no write pending.
- `o_err` out 1: sticky protocol error.

## Operation
- Per id state: `wptr` (`HBW` bits, offset within region) and `cnt` (`CNT_BW`, occupied rows). Also stored: `base`, `size`.
- Config load (`i_cfg_dval`): latches `base`/`size`, clears every `wptr`/`cnt`. Allowed only when `o_idle`; load while not idle still takes effect and sets `o_err`.
- Accept: `o_din_ack = i_din_rdy && id<N_ICFG && cnt[id] < size[id] && !i_cfg_dval`. Combinational from registered state; a free in the same cycle does not raise ack that cycle.
- Transfer (rdy&&ack): register `o_wid=id`, `o_whiaddr = base[id]+wptr[id]` (mod `1<<HBW`, regions do not wrap the array by contract), `o_wdata=i_din_data`; `wptr[id]` increments, wrapping to 0 when it reaches `size[id]-1`; `cnt[id]++`.
- Free: `cnt[free_id]--`. Same-cycle transfer and free on the same id: `cnt` unchanged, `wptr` still advances.
- Error conditions (set `o_err`, state otherwise unchanged for that event): free with `cnt==0`; free/din with id ≥ `N_ICFG` (din with such id is never acked; producer stall is the bench's concern); config while not idle.
- `o_idle = !o_wad_dval && all cnt==0`.

## Timing
- Reset: `o_wad_dval=0`, `o_wid=0`, `o_whiaddr=0`, `o_wdata` all 0, `o_err=0`, `o_idle=1`, `o_din_ack=0`; all `wptr`,`cnt`,`base`,`size` = 0 (all ids disabled until config).
- Reset has priority over config, transfer, free; reset mid-stream drops the pending write (`o_wad_dval` low next cycle).
- Write latency: `o_wad_dval` high exactly the cycle after a transfer, for one cycle; back-to-back transfers give back-to-back writes (one row/cycle sustained).
- Full boundary: with `cnt==size`, ack stays low until the cycle after the free is sampled.
- rdyack: producer holds `i_din_rdy`, id and data stable until ack; ack never asserts without rdy.
- No wad backpressure: the cache accepts every `wad_dval`.

## Test plan
- VSIZE=32, LBW=10 (HBW=5). Config id0 base 0 size 4, id1 base 8 size 3; 5 fills to id0 back-to-back -> writes at whiaddr 0,1,2,3, each 1 cycle after ack; 5th not acked, `cnt[0]=4`.
- Same state, free id0 -> ack of 5th fill the cycle after free; write at whiaddr 0 (wrap), `cnt[0]` stays 4.
- Interleave fills id1 x4 and id0 with a free id1 on the same cycle as the 3rd id1 fill -> id1 writes 8,9,10, then 4th at 8; `cnt[1]=3`; no `o_err`.
- Free id0 while `cnt[0]==0` -> `o_err=1` next cycle and sticky; cnt stays 0; fill to size-0 id2 never acked.
- Config issued with `cnt[1]=2` -> `o_err=1`, all counters cleared, `o_idle=1` next cycle.
- Assert `i_rst` the cycle after a transfer -> `o_wad_dval=0` next cycle, all outputs at reset values, `o_din_ack=0` until reconfigured.

Source files
------------

// File: rtl/remap_cache_filler.sv
// Fill-side controller for the banked remap cache: allocates rows in each input-config
// id's circular region, drives the cache write port and reclaims rows on free events.
module remap_cache_filler #(
    parameter int LBW    = 10,
    parameter int DBW    = 8,
    parameter int N_ICFG = 4,
    parameter int VSIZE  = 32,
    localparam int ICFG_BW = $clog2(N_ICFG + 1),
    localparam int CV_BW   = $clog2(VSIZE),
    localparam int HBW     = LBW - CV_BW,
    localparam int CNT_BW  = HBW + 1,
    localparam int IDX_BW  = (N_ICFG > 1) ? $clog2(N_ICFG) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cfg_dval,
    input  logic [HBW-1:0]     i_cfg_base [N_ICFG],
    input  logic [CNT_BW-1:0]  i_cfg_size [N_ICFG],
    input  logic               i_din_rdy,
    output logic               o_din_ack,
    input  logic [ICFG_BW-1:0] i_din_id,
    input  logic [DBW-1:0]     i_din_data [VSIZE],
    input  logic               i_free_dval,
    input  logic [ICFG_BW-1:0] i_free_id,
    output logic               o_wad_dval,
    output logic [ICFG_BW-1:0] o_wid,
    output logic [HBW-1:0]     o_whiaddr,
    output logic [DBW-1:0]     o_wdata [VSIZE],
    output logic               o_idle,
    output logic               o_err
);

    logic [HBW-1:0]     base_q [N_ICFG];
    logic [HBW-1:0]     base_d [N_ICFG];
    logic [CNT_BW-1:0]  size_q [N_ICFG];
    logic [CNT_BW-1:0]  size_d [N_ICFG];
    logic [HBW-1:0]     wptr_q [N_ICFG];
    logic [HBW-1:0]     wptr_d [N_ICFG];
    logic [CNT_BW-1:0]  cnt_q  [N_ICFG];
    logic [CNT_BW-1:0]  cnt_d  [N_ICFG];
    logic               wad_dval_q, wad_dval_d;
    logic [ICFG_BW-1:0] wid_q, wid_d;
    logic [HBW-1:0]     whiaddr_q, whiaddr_d;
    logic [DBW-1:0]     wdata_q [VSIZE];
    logic [DBW-1:0]     wdata_d [VSIZE];
    logic               err_q, err_d;

    logic              din_id_ok, free_id_ok, free_ok, any_busy;
    logic [IDX_BW-1:0] din_idx, free_idx;

    assign din_idx    = i_din_id[IDX_BW-1:0];
    assign free_idx   = i_free_id[IDX_BW-1:0];
    assign din_id_ok  = i_din_id < ICFG_BW'(N_ICFG);
    assign free_id_ok = i_free_id < ICFG_BW'(N_ICFG);

    // Ack looks only at registered occupancy, so a same-cycle free cannot open a full region.
    assign o_din_ack = i_din_rdy && din_id_ok && !i_cfg_dval
                       && (cnt_q[din_idx] < size_q[din_idx]);
    assign free_ok   = i_free_dval && free_id_ok && !i_cfg_dval && (cnt_q[free_idx] != '0);

    always_comb begin
        any_busy = 1'b0;
        for (int i = 0; i < N_ICFG; i++) begin
            if (cnt_q[i] != '0) any_busy = 1'b1;
        end
    end

    assign o_idle     = !wad_dval_q && !any_busy;
    assign o_wad_dval = wad_dval_q;
    assign o_wid      = wid_q;
    assign o_whiaddr  = whiaddr_q;
    assign o_wdata    = wdata_q;
    assign o_err      = err_q;

    always_comb begin
        base_d     = base_q;
        size_d     = size_q;
        wptr_d     = wptr_q;
        cnt_d      = cnt_q;
        wad_dval_d = 1'b0;
        wid_d      = wid_q;
        whiaddr_d  = whiaddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;

        if (i_din_rdy && !din_id_ok) err_d = 1'b1;
        if (i_free_dval && !free_id_ok) err_d = 1'b1;

        if (i_cfg_dval) begin
            base_d = i_cfg_base;
            size_d = i_cfg_size;
            for (int i = 0; i < N_ICFG; i++) begin
                wptr_d[i] = '0;
                cnt_d[i]  = '0;
            end
            if (!o_idle) err_d = 1'b1;
        end else begin
            if (i_free_dval && free_id_ok && cnt_q[free_idx] == '0) err_d = 1'b1;

            if (o_din_ack) begin
                wad_dval_d = 1'b1;
                wid_d      = i_din_id;
                whiaddr_d  = base_q[din_idx] + wptr_q[din_idx];
                wdata_d    = i_din_data;
                if ({1'b0, wptr_q[din_idx]} == size_q[din_idx] - CNT_BW'(1)) begin
                    wptr_d[din_idx] = '0;
                end else begin
                    wptr_d[din_idx] = wptr_q[din_idx] + HBW'(1);
                end
            end

            // A transfer and a free on the same id cancel out in the occupancy count.
            for (int i = 0; i < N_ICFG; i++) begin
                if (o_din_ack && din_idx == IDX_BW'(i) && !(free_ok && free_idx == IDX_BW'(i))) begin
                    cnt_d[i] = cnt_q[i] + CNT_BW'(1);
                end else if (free_ok && free_idx == IDX_BW'(i)
                             && !(o_din_ack && din_idx == IDX_BW'(i))) begin
                    cnt_d[i] = cnt_q[i] - CNT_BW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base_q     <= '{default: '0};
            size_q     <= '{default: '0};
            wptr_q     <= '{default: '0};
            cnt_q      <= '{default: '0};
            wad_dval_q <= 1'b0;
            wid_q      <= '0;
            whiaddr_q  <= '0;
            wdata_q    <= '{default: '0};
            err_q      <= 1'b0;
        end else begin
            base_q     <= base_d;
            size_q     <= size_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            wad_dval_q <= wad_dval_d;
            wid_q      <= wid_d;
            whiaddr_q  <= whiaddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

endmodule
